xocc_cmd_arb: RTL and testbench

Round-robin arbiter sharing the XOCC command-FIFO write port among NREQ requesters (CPU custom-instruction path, autonomous issue engines). It latches one requester's queue id and payload, waits for the target command FIFO to have space, then issues a single-cycle one-hot write enable with the payload. It sits between the requesters and the per-queue command FIFOs, on the xocc_clk domain. Optionally, it aborts requests stalled on a full queue after a bounded wait.

---
 rtl/xocc_cmd_arb_if.sv | 27 ++
 rtl/xocc_cmd_arb.sv | 185 ++++++++++++++++++
 tb/tb_xocc_cmd_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xocc_cmd_arb_if.sv
// Requester/command-FIFO side signals of the XOCC command arbiter.
// master = requesters plus FIFO full flags, slave = the arbiter itself.
interface xocc_cmd_arb_if #(
    parameter int NREQ = 4,
    parameter int NQ   = 16,
    parameter int QW   = 4,
    parameter int DW   = 96
);
    logic [NREQ-1:0]    req_vld;
    logic [NREQ*QW-1:0] req_qid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ack;
    logic               req_err;
    logic [NQ-1:0]      full_cmd;
    logic [NQ-1:0]      wr_en_cmd;
    logic [DW-1:0]      cmd_din;

    modport master (
        output req_vld, req_qid, req_data, full_cmd,
        input  req_ack, req_err, wr_en_cmd, cmd_din
    );

    modport slave (
        input  req_vld, req_qid, req_data, full_cmd,
        output req_ack, req_err, wr_en_cmd, cmd_din
    );
endinterface

// File: rtl/xocc_cmd_arb.sv
// Round-robin arbiter for the XOCC command-FIFO write port: grant, push 2 cycles later, waits while full.
// Optional stall abort after TMO cycles when XOCC_ARB_TIMEOUT_EN is defined.
module xocc_cmd_arb #(
    parameter int NREQ    = 4,
    parameter int NQ      = 16,
    parameter int NQ_IMPL = 2,
    parameter int QW      = 4,
    parameter int DW      = 96,
    parameter int TMO     = 255
) (
    input  logic                 xocc_clk,
    input  logic                 cpurst_b,
    xocc_cmd_arb_if.slave        bus,
    output logic                 arb_busy,
    output logic                 timeout_err,
    output logic [15:0]          push_cnt
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || NQ_IMPL > NQ || TMO < 1 || TMO > 255) begin : g_bad_param
        $error("xocc_cmd_arb: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [QW-1:0]   qid, qid_nxt;
    logic [DW-1:0]   data, data_nxt;
    logic [NREQ-1:0] ack, ack_nxt;
    logic            err, err_nxt;
    logic [NQ-1:0]   wr_en, wr_en_nxt;
    logic [DW-1:0]   din, din_nxt;
    logic [15:0]     push_q, push_nxt;
    logic            do_push;

    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
    int              pos;
    logic            q_full;
    logic            qid_legal;

    assign q_full    = bus.full_cmd[qid];
    assign qid_legal = (int'(qid) < NQ_IMPL);

    // Rotating priority: scan starts just after the last served requester.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        pos     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = int'(last) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!gnt_vld && bus.req_vld[pos[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = pos[IW-1:0];
            end
        end
    end

`ifdef XOCC_ARB_TIMEOUT_EN
    logic [7:0] stall, stall_nxt;
    logic       tmo_q, tmo_set;
`endif

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        idx_nxt   = idx;
        qid_nxt   = qid;
        data_nxt  = data;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        wr_en_nxt = '0;
        din_nxt   = '0;
        push_nxt  = push_q;
        do_push   = 1'b0;
`ifdef XOCC_ARB_TIMEOUT_EN
        stall_nxt = stall;
        tmo_set   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    idx_nxt   = gnt_idx;
                    qid_nxt   = bus.req_qid[int'(gnt_idx)*QW +: QW];
                    data_nxt  = bus.req_data[int'(gnt_idx)*DW +: DW];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!qid_legal) begin
                    ack_nxt[idx] = 1'b1;
                    err_nxt      = 1'b1;
                    state_nxt    = ACK;
                end else if (!q_full) begin
                    do_push = 1'b1;
                end else begin
`ifdef XOCC_ARB_TIMEOUT_EN
                    stall_nxt = '0;
`endif
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A queue that frees up on the last allowed cycle still gets the push.
                if (!q_full) begin
                    do_push = 1'b1;
`ifdef XOCC_ARB_TIMEOUT_EN
                end else if (stall == 8'(TMO)) begin
                    ack_nxt[idx] = 1'b1;
                    err_nxt      = 1'b1;
                    tmo_set      = 1'b1;
                    state_nxt    = ACK;
                end else begin
                    stall_nxt = stall + 8'd1;
`endif
                end
            end
            ACK: begin
                last_nxt  = idx;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (do_push) begin
            wr_en_nxt    = NQ'(1) << qid;
            din_nxt      = data;
            ack_nxt[idx] = 1'b1;
            push_nxt     = push_q + 16'd1;
            state_nxt    = ACK;
        end
    end

    always_ff @(posedge xocc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state  <= IDLE;
            last   <= IW'(NREQ - 1);
            idx    <= '0;
            qid    <= '0;
            data   <= '0;
            ack    <= '0;
            err    <= 1'b0;
            wr_en  <= '0;
            din    <= '0;
            push_q <= '0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            idx    <= idx_nxt;
            qid    <= qid_nxt;
            data   <= data_nxt;
            ack    <= ack_nxt;
            err    <= err_nxt;
            wr_en  <= wr_en_nxt;
            din    <= din_nxt;
            push_q <= push_nxt;
        end
    end

`ifdef XOCC_ARB_TIMEOUT_EN
    always_ff @(posedge xocc_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            stall <= '0;
            tmo_q <= 1'b0;
        end else begin
            stall <= stall_nxt;
            if (tmo_set) tmo_q <= 1'b1;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign bus.req_ack   = ack;
    assign bus.req_err   = err;
    assign bus.wr_en_cmd = wr_en;
    assign bus.cmd_din   = din;
    assign arb_busy      = (state != IDLE);
    assign push_cnt      = push_q;

endmodule

// File: tb/tb_xocc_cmd_arb.sv
// Self-checking bench for xocc_cmd_arb: vector table, hand sequences, randomized run vs. a transaction model.
module tb_xocc_cmd_arb;
    localparam int NREQ = 4, NQ = 16, NQ_IMPL = 2, QW = 4, DW = 96, TMO = 255;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    xocc_cmd_arb_if #(.NREQ(NREQ), .NQ(NQ), .QW(QW), .DW(DW)) bus ();
    logic        arb_busy, timeout_err;
    logic [15:0] push_cnt;

    xocc_cmd_arb #(.NREQ(NREQ), .NQ(NQ), .NQ_IMPL(NQ_IMPL), .QW(QW), .DW(DW), .TMO(TMO)) dut (
        .xocc_clk(clk), .cpurst_b(rst_b), .bus(bus),
        .arb_busy(arb_busy), .timeout_err(timeout_err), .push_cnt(push_cnt)
    );

    int errors = 0, checks = 0;
    int exp_push = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Protocol monitor: no push into a queue seen full at the deciding edge, one-hot strobes.
    logic [NQ-1:0] full_q;
    int viol = 0;
    always @(posedge clk) full_q <= bus.full_cmd;
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            if ((bus.wr_en_cmd & full_q) != '0 || !$onehot0(bus.wr_en_cmd) || !$onehot0(bus.req_ack) ||
                ((bus.wr_en_cmd != '0) != (bus.req_ack != '0 && !bus.req_err)))
                viol++;
        end
    end

    task automatic set_req(int i, logic [QW-1:0] q, logic [DW-1:0] d);
        bus.req_vld[i]           = 1'b1;
        bus.req_qid[i*QW +: QW]  = q;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic wait_ack(input int limit, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (bus.req_ack == '0 && lat < limit);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_ack"},  128'(bus.req_ack),   128'(0));
        check({tag, "_err"},  128'(bus.req_err),   128'(0));
        check({tag, "_wr"},   128'(bus.wr_en_cmd), 128'(0));
        check({tag, "_din"},  128'(bus.cmd_din),   128'(0));
        check({tag, "_busy"}, 128'(arb_busy),      128'(0));
        check({tag, "_tmo"},  128'(timeout_err),   128'(0));
        check({tag, "_cnt"},  128'(push_cnt),      128'(0));
    endtask

    typedef struct {
        logic [NREQ-1:0] vld;
        logic [QW-1:0]   qid;
        int              exp_idx;
        logic            exp_err;
        logic [NQ-1:0]   exp_wr;
    } vec_t;
    vec_t tbl[8];

    logic [DW-1:0] dat[NREQ];
    logic [DW-1:0] d;
    int lat, stray, cyc, last_m, e_idx, rem_sum;
    int rem[NREQ];
    logic [QW-1:0] cur_qid[NREQ];
    logic exp_err;

    initial begin
        rst_b = 1'b0;
        bus.req_vld = '0; bus.req_qid = '0; bus.req_data = '0; bus.full_cmd = '0;

        // Reset state, during and right after reset
        repeat (3) @(negedge clk);
        check_all_zero("rst_in");
        rst_b = 1'b1;
        @(negedge clk);
        check_all_zero("rst_out");

        tbl[0] = '{4'b0001, 4'd1,  0, 1'b0, 16'h0002};
        tbl[1] = '{4'b1111, 4'd0,  1, 1'b0, 16'h0001};
        tbl[2] = '{4'b1001, 4'd5,  3, 1'b1, 16'h0000};
        tbl[3] = '{4'b0110, 4'd1,  1, 1'b0, 16'h0002};
        tbl[4] = '{4'b0001, 4'd15, 0, 1'b1, 16'h0000};
        tbl[5] = '{4'b0011, 4'd0,  1, 1'b0, 16'h0001};
        tbl[6] = '{4'b0011, 4'd1,  0, 1'b0, 16'h0002};
        tbl[7] = '{4'b1100, 4'd2,  2, 1'b1, 16'h0000};

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < NREQ; i++) begin
                dat[i] = (v == 0 && i == 0) ? {12{8'hA5}} : {$urandom, $urandom, $urandom};
                if (tbl[v].vld[i]) set_req(i, tbl[v].qid, dat[i]);
            end
            wait_ack(10, lat);
            check("vec_lat",  128'(lat), 128'(2));
            check("vec_ack",  128'(bus.req_ack), 128'(4'b0001 << tbl[v].exp_idx));
            check("vec_err",  128'(bus.req_err), 128'(tbl[v].exp_err));
            check("vec_wr",   128'(bus.wr_en_cmd), 128'(tbl[v].exp_wr));
            if (!tbl[v].exp_err) begin
                check("vec_din", 128'(bus.cmd_din), 128'(dat[tbl[v].exp_idx]));
                exp_push++;
            end
            check("vec_cnt",  128'(push_cnt), 128'(exp_push));
            bus.req_vld = '0;
            @(negedge clk);
            check("vec_idle", 128'(arb_busy), 128'(0));
        end

        // Round-robin with all requesters held: 0,1,2,3,0 every 3 cycles
        rst_b = 1'b0; exp_push = 0;
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd0, {$urandom, $urandom, $urandom});
        for (int e = 0; e < 5; e++) begin
            wait_ack(10, lat);
            check("rr_lat", 128'(lat), 128'((e == 0) ? 2 : 3));
            check("rr_ack", 128'(bus.req_ack), 128'(4'b0001 << (e % 4)));
            check("rr_wr",  128'(bus.wr_en_cmd), 128'(16'h0001));
            exp_push++;
            if (e < 4) set_req(e % 4, 4'd0, {$urandom, $urandom, $urandom});
            else bus.req_vld = '0;
        end
        @(negedge clk);
        check("rr_cnt", 128'(push_cnt), 128'(5));

        // Backpressure: queue 0 full for 10 cycles
        bus.full_cmd[0] = 1'b1;
        d = {$urandom, $urandom, $urandom};
        set_req(2, 4'd0, d);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.req_ack != '0) stray++;
        end
        bus.full_cmd[0] = 1'b0;
        wait_ack(10, lat);
        exp_push++;
        check("bp_stray", 128'(stray), 128'(0));
        check("bp_lat",   128'(lat), 128'(1));
        check("bp_ack",   128'(bus.req_ack), 128'(4'b0100));
        check("bp_err",   128'(bus.req_err), 128'(0));
        check("bp_wr",    128'(bus.wr_en_cmd), 128'(16'h0001));
        check("bp_din",   128'(bus.cmd_din), 128'(d));
        check("bp_tmo",   128'(timeout_err), 128'(0));
        bus.req_vld = '0;
        @(negedge clk);

`ifdef XOCC_ARB_TIMEOUT_EN
        // Queue frees on the very cycle the stall counter reaches TMO: push wins
        bus.full_cmd[1] = 1'b1;
        set_req(3, 4'd1, {$urandom, $urandom, $urandom});
        stray = 0;
        repeat (TMO + 2) begin
            @(negedge clk);
            if (bus.req_ack != '0) stray++;
        end
        bus.full_cmd[1] = 1'b0;
        wait_ack(10, lat);
        exp_push++;
        check("edge_stray", 128'(stray), 128'(0));
        check("edge_lat",   128'(lat), 128'(1));
        check("edge_err",   128'(bus.req_err), 128'(0));
        check("edge_wr",    128'(bus.wr_en_cmd), 128'(16'h0002));
        check("edge_tmo",   128'(timeout_err), 128'(0));
        bus.req_vld = '0;
        @(negedge clk);

        // Stuck full queue aborts at T+2+TMO+1
        bus.full_cmd[1] = 1'b1;
        set_req(1, 4'd1, {$urandom, $urandom, $urandom});
        wait_ack(400, lat);
        check("tmo_lat", 128'(lat), 128'(TMO + 3));
        check("tmo_ack", 128'(bus.req_ack), 128'(4'b0010));
        check("tmo_err", 128'(bus.req_err), 128'(1));
        check("tmo_wr",  128'(bus.wr_en_cmd), 128'(0));
        check("tmo_flag", 128'(timeout_err), 128'(1));
        check("tmo_cnt", 128'(push_cnt), 128'(exp_push));
        bus.req_vld = '0;
        bus.full_cmd = '0;
        @(negedge clk);
        set_req(0, 4'd0, {$urandom, $urandom, $urandom});
        wait_ack(10, lat);
        exp_push++;
        check("tmo_sticky_err", 128'(bus.req_err), 128'(0));
        check("tmo_sticky", 128'(timeout_err), 128'(1));
        bus.req_vld = '0;
        @(negedge clk);
`else
        // Without the abort a stall lasts as long as the queue stays full
        bus.full_cmd[1] = 1'b1;
        set_req(3, 4'd1, {$urandom, $urandom, $urandom});
        stray = 0;
        repeat (300) begin
            @(negedge clk);
            if (bus.req_ack != '0) stray++;
        end
        check("hold_stray", 128'(stray), 128'(0));
        check("hold_busy",  128'(arb_busy), 128'(1));
        bus.full_cmd[1] = 1'b0;
        wait_ack(10, lat);
        exp_push++;
        check("hold_lat", 128'(lat), 128'(1));
        check("hold_err", 128'(bus.req_err), 128'(0));
        check("hold_wr",  128'(bus.wr_en_cmd), 128'(16'h0002));
        check("hold_tmo", 128'(timeout_err), 128'(0));
        bus.req_vld = '0;
        @(negedge clk);
`endif

        // Reset while stalled in WAIT
        bus.full_cmd[1] = 1'b1;
        set_req(2, 4'd1, {$urandom, $urandom, $urandom});
        repeat (5) @(negedge clk);
        check("mid_busy", 128'(arb_busy), 128'(1));
        rst_b = 1'b0;
        #1;
        check_all_zero("mid_rst");
        bus.req_vld = '0;
        bus.full_cmd = '0;
        exp_push = 0;
        @(negedge clk);
        rst_b = 1'b1;
        set_req(0, 4'd0, {$urandom, $urandom, $urandom});
        set_req(3, 4'd0, {$urandom, $urandom, $urandom});
        wait_ack(10, lat);
        exp_push++;
        check("mid_lat", 128'(lat), 128'(2));
        check("mid_ack", 128'(bus.req_ack), 128'(4'b0001));
        bus.req_vld = '0;
        @(negedge clk);

        // Randomized run: per-requester request streams, random full flags
        last_m = 0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = $urandom_range(0, 8);
            cur_qid[i] = QW'($urandom_range(0, 3));
            dat[i] = {$urandom, $urandom, $urandom};
            if (rem[i] > 0) set_req(i, cur_qid[i], dat[i]);
        end
        rem_sum = rem[0] + rem[1] + rem[2] + rem[3];
        cyc = 0;
        while (rem_sum > 0 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
            if (bus.req_ack != '0) begin
                e_idx = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (e_idx < 0 && rem[(last_m + k) % NREQ] > 0) e_idx = (last_m + k) % NREQ;
                exp_err = (cur_qid[e_idx] >= QW'(NQ_IMPL));
                check("rnd_ack", 128'(bus.req_ack), 128'(4'b0001 << e_idx));
                check("rnd_err", 128'(bus.req_err), 128'(exp_err));
                check("rnd_wr",  128'(bus.wr_en_cmd), exp_err ? 128'(0) : 128'(16'h0001 << cur_qid[e_idx]));
                if (!exp_err) begin
                    check("rnd_din", 128'(bus.cmd_din), 128'(dat[e_idx]));
                    exp_push++;
                end
                check("rnd_cnt", 128'(push_cnt), 128'(exp_push));
                rem[e_idx]--;
                rem_sum--;
                last_m = e_idx;
                if (rem[e_idx] > 0) begin
                    cur_qid[e_idx] = QW'($urandom_range(0, 3));
                    dat[e_idx] = {$urandom, $urandom, $urandom};
                    set_req(e_idx, cur_qid[e_idx], dat[e_idx]);
                end else begin
                    bus.req_vld[e_idx] = 1'b0;
                end
            end
            bus.full_cmd = NQ'($urandom);
        end
        check("rnd_done", 128'(rem_sum), 128'(0));
        bus.full_cmd = '0;
        @(negedge clk);
        check("protocol_viol", 128'(viol), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
